// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard / flush / halt controller.
package pipe_ctrl_pkg;

    localparam int SB_RD_W = 5;
    localparam logic [SB_RD_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_MEM_WB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
        logic               is_halt;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // A source only hits a live writer; x0 never hits because non-writers carry rd = x0.
    function automatic logic src_hit(input sb_entry_t e, input logic [SB_RD_W-1:0] rs,
                                     input logic used);
        return used && (rs != REG_X0) && e.valid && (e.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// In-flight destination scoreboard (EX, MEM, WB) with per-source match vectors.
module pipe_ctrl_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    input  logic               bubble,
    input  logic               flush,
    input  sb_entry_t          id_entry,
    input  logic [SB_RD_W-1:0] rs1,
    input  logic               rs1_used,
    input  logic [SB_RD_W-1:0] rs2,
    input  logic               rs2_used,
    output logic [2:0]         match_rs1,
    output logic [2:0]         match_rs2,
    output logic               ex_is_load,
    output logic               ex_is_halt,
    output logic               mem_is_halt
);

    sb_entry_t ex_q;
    sb_entry_t mem_q;
    sb_entry_t wb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else if (advance) begin
            wb_q  <= mem_q;
            mem_q <= flush ? SB_EMPTY : ex_q;
            ex_q  <= (bubble || flush) ? SB_EMPTY : id_entry;
        end
    end

    // Bit 0 = EX, bit 1 = MEM, bit 2 = WB.
    assign match_rs1 = {src_hit(wb_q, rs1, rs1_used), src_hit(mem_q, rs1, rs1_used),
                        src_hit(ex_q, rs1, rs1_used)};
    assign match_rs2 = {src_hit(wb_q, rs2, rs2_used), src_hit(mem_q, rs2, rs2_used),
                        src_hit(ex_q, rs2, rs2_used)};

    assign ex_is_load  = ex_q.valid & ex_q.is_load;
    assign ex_is_halt  = ex_q.valid & ex_q.is_halt;
    assign mem_is_halt = mem_q.valid & mem_q.is_halt;

    logic unused_fields;
    assign unused_fields = wb_q.is_load ^ wb_q.is_halt ^ mem_q.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and halt sequencer for the 5-stage pipeline.
// Build option: PIPE_FWD_EN adds registered forwarding selects and relaxes stalls to load-use.
//
//   state  | meaning
//   RUN    | normal issue; RAW stalls and branch flushes applied
//   DRAIN  | halt issued; fetch held, bubbles fed until halt reaches WB
//   HALTED | sticky halt; everything held, flushes ignored, exit by reset
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit WB_WRITE_FIRST = 1'b1,
    parameter int REG_ADDR_W     = SB_RD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_wr,
    input  logic                  id_is_load,
    input  logic                  id_is_halt,
    input  logic                  mem_branch_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  ohalt
`ifdef PIPE_FWD_EN
    ,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel
`endif
);

    ctrl_state_e state_q;
    sb_entry_t   id_entry;
    logic [2:0]  match_rs1;
    logic [2:0]  match_rs2;
    logic        ex_is_load;
    logic        ex_is_halt;
    logic        mem_is_halt;
    logic        flush;
    logic        hazard_raw;
    logic        hazard_stall;
    logic        issue;

    assign id_entry.valid   = id_valid & ((id_rd_wr & (id_rd != REG_X0)) | id_is_halt);
    assign id_entry.rd      = id_rd_wr ? id_rd : REG_X0;
    assign id_entry.is_load = id_is_load;
    assign id_entry.is_halt = id_is_halt;

    pipe_ctrl_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .advance    (1'b1),
        .bubble     (~issue),
        .flush      (flush),
        .id_entry   (id_entry),
        .rs1        (id_rs1),
        .rs1_used   (id_rs1_used),
        .rs2        (id_rs2),
        .rs2_used   (id_rs2_used),
        .match_rs1  (match_rs1),
        .match_rs2  (match_rs2),
        .ex_is_load (ex_is_load),
        .ex_is_halt (ex_is_halt),
        .mem_is_halt(mem_is_halt)
    );

`ifdef PIPE_FWD_EN
    logic     wb_only;
    fwd_sel_e sel1_d;
    fwd_sel_e sel2_d;

    // A WB-only hit is not covered by the EX/MEM bypass when the regfile is write-after-read.
    assign wb_only = (match_rs1[2] & ~match_rs1[1] & ~match_rs1[0])
                   | (match_rs2[2] & ~match_rs2[1] & ~match_rs2[0]);
    assign hazard_raw = id_valid & ((ex_is_load & (match_rs1[0] | match_rs2[0]))
                                    | (~WB_WRITE_FIRST & wb_only));

    assign sel1_d = match_rs1[0] ? FWD_EX_MEM : (match_rs1[1] ? FWD_MEM_WB : FWD_RF);
    assign sel2_d = match_rs2[0] ? FWD_EX_MEM : (match_rs2[1] ? FWD_MEM_WB : FWD_RF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_rs1_sel <= FWD_RF;
            fwd_rs2_sel <= FWD_RF;
        end else begin
            fwd_rs1_sel <= issue ? sel1_d : FWD_RF;
            fwd_rs2_sel <= issue ? sel2_d : FWD_RF;
        end
    end
`else
    assign hazard_raw = id_valid & ((|match_rs1[1:0]) | (|match_rs2[1:0])
                                    | (~WB_WRITE_FIRST & (match_rs1[2] | match_rs2[2])));

    logic unused_fwd;
    assign unused_fwd = ex_is_load;
`endif

    assign flush        = mem_branch_taken & (state_q != HALTED);
    assign hazard_stall = (state_q == RUN) & hazard_raw & ~mem_branch_taken;
    assign issue        = (state_q == RUN) & id_valid & ~hazard_raw & ~mem_branch_taken;

    // A flush during DRAIN releases fetch so the redirect can land.
    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        bubble_ex    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        unique case (state_q)
            RUN: begin
                stall_if     = hazard_stall;
                stall_id     = hazard_stall;
                bubble_ex    = hazard_stall;
                flush_if_id  = flush;
                flush_id_ex  = flush;
                flush_ex_mem = flush;
            end
            DRAIN: begin
                stall_if     = ~flush;
                bubble_ex    = 1'b1;
                flush_if_id  = flush;
                flush_id_ex  = flush;
                flush_ex_mem = flush;
            end
            HALTED: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: ;
        endcase
    end

    // HALTED is entered on the edge that moves the halt into WB, three cycles after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            ohalt   <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (issue && id_is_halt) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (flush && ex_is_halt) begin
                        state_q <= RUN;
                    end else if (mem_is_halt) begin
                        state_q <= HALTED;
                        ohalt   <= 1'b1;
                    end
                end
                HALTED: ohalt <= 1'b1;
                default: state_q <= RUN;
            endcase
        end
    end

endmodule
